// File: rtl/cpu_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package cpu_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/dmem_arb_select.sv
// Winner selection between CPU and loader ports, with the loader starvation counter.
module dmem_arb_select
  import cpu_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0_i,
  input  logic req1_i,
  input  logic grant_i,
  output logic winner_o
);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    winner_o = PORT_CPU;
    if (req1_i && (!req0_i || starve_cnt_q == CNT_W'(STARVE_MAX))) winner_o = PORT_LDR;
  end

  // Only a CPU grant that actually passes over a waiting loader counts toward starvation.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_i) begin
      if (winner_o == PORT_CPU && req1_i) begin
        if (starve_cnt_q != '1) starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares a single-port data memory between the CPU memory stage (port 0) and the loader (port 1).
// Valid/ready: reqN is held with stable we/addr/wdata until ackN pulses for one cycle; ackN is the only completion.
module dmem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          stall0,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output arb_state_t    dbg_state
);

  localparam int LAT_W = 4;

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("dmem_port_arbiter: MEM_LAT must be within 1..15");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("dmem_port_arbiter: STARVE_MAX must be within 1..15");
  end

  arb_state_t       state_q;
  logic [LAT_W-1:0] lat_q;
  logic             owner_q;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic             mem_en_q, mem_we_q;
  logic             ack0_q, ack1_q;
  logic [DW-1:0]    rdata0_q, rdata1_q;

  logic winner;
  logic grant;

  assign grant = (state_q == ARB_IDLE) && (req0 || req1);

  dmem_arb_select #(
    .STARVE_MAX(STARVE_MAX)
  ) u_select (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0_i  (req0),
    .req1_i  (req1),
    .grant_i (grant),
    .winner_o(winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      lat_q    <= '0;
      owner_q  <= PORT_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (grant) begin
            owner_q  <= winner;
            we_q     <= winner ? we1 : we0;
            addr_q   <= winner ? addr1 : addr0;
            wdata_q  <= winner ? wdata1 : wdata0;
            mem_en_q <= 1'b1;
            mem_we_q <= winner ? we1 : we0;
            lat_q    <= LAT_W'(1);
            state_q  <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          // Read data is sampled on the edge that leaves the last access cycle.
          if (lat_q == LAT_W'(MEM_LAT)) begin
            state_q <= ARB_DONE;
            if (owner_q == PORT_LDR) begin
              ack1_q <= 1'b1;
              if (!we_q) rdata1_q <= mem_rdata;
            end else begin
              ack0_q <= 1'b1;
              if (!we_q) rdata0_q <= mem_rdata;
            end
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        ARB_DONE: state_q <= ARB_IDLE;
        default:  state_q <= ARB_IDLE;
      endcase
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign stall0    = req0 & ~ack0_q;
  assign busy      = (state_q != ARB_IDLE);
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign dbg_state = state_q;

endmodule
